// File: rtl/pipe_controlunit.sv
// Control and hazard unit for the F/D/E/M/W RV32I pipe: decodes D, carries the
// control fields through E/M/W, and produces stall/flush/forward selects and event counts.

module pipe_cu_fwd #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       wr_m_i,
    input  logic       wr_w_i,
    output logic [1:0] sel_o
);
    // M is younger than W, so it wins when both write the same register
    always_comb begin
        sel_o = 2'b00;
        if (FWD_EN) begin
            if (wr_m_i && rd_m_i != 5'd0 && rd_m_i == rs_i)
                sel_o = 2'b10;
            else if (wr_w_i && rd_w_i != 5'd0 && rd_w_i == rs_i)
                sel_o = 2'b01;
        end
    end
endmodule

module pipe_controlunit #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_d,
    input  logic             valid_d,
    input  logic             branch_taken_e,
    output logic             regwrite_e,
    output logic             alusrc_e,
    output logic             memwrite_e,
    output logic             resultsrc_e,
    output logic             pcwritemux_e,
    output logic             jbmux_e,
    output logic             addupper_e,
    output logic [3:0]       aluctrl_e,
    output logic [2:0]       immsrc_d,
    output logic             regwrite_m,
    output logic             memwrite_m,
    output logic             resultsrc_m,
    output logic             pcwritemux_m,
    output logic             regwrite_w,
    output logic             resultsrc_w,
    output logic             pcwritemux_w,
    output logic [4:0]       rd_e,
    output logic [4:0]       rd_m,
    output logic [4:0]       rd_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int STAGES = 2;
    localparam logic [6:0] OP_IMM = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23,
                           OP_BR  = 7'h63, OP_REG  = 7'h33, OP_LUI   = 7'h37,
                           OP_AUI = 7'h17, OP_JAL  = 7'h6F, OP_JALR  = 7'h67;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic       regwrite;
        logic       alusrc;
        logic       memwrite;
        logic       resultsrc;
        logic       pcwritemux;
        logic       jbmux;
        logic       addupper;
        logic [3:0] aluctrl;
    } ctrl_t;

    typedef struct packed {
        ctrl_t      c;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } de_t;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       resultsrc;
        logic       pcwritemux;
        logic [4:0] rd;
    } em_t;

    typedef struct packed {
        logic       regwrite;
        logic       resultsrc;
        logic       pcwritemux;
        logic [4:0] rd;
    } mw_t;

    de_t              de_q, de_d;
    em_t              em_q, em_d;
    mw_t              mw_q, mw_d;
    logic [STAGES:0]  vld_pipe_q, vld_pipe_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7b;
    ctrl_t      dec_c;
    logic       use_rs1, use_rs2;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       wr_e, wr_m, wr_w, hazard;
    logic       unused_instr;

    assign opc   = instr_d[6:0];
    assign f3    = instr_d[14:12];
    assign rs1_d = use_rs1 ? instr_d[19:15] : 5'd0;
    assign rs2_d = use_rs2 ? instr_d[24:20] : 5'd0;
    assign rd_d  = dec_c.regwrite ? instr_d[11:7] : 5'd0;
    assign f7b   = instr_d[30] & (((opc == OP_IMM) & (f3 == 3'd5)) |
                                  ((opc == OP_REG) & ((f3 == 3'd0) | (f3 == 3'd5))));
    assign unused_instr = ^{instr_d[31], instr_d[29:25]};

    always_comb begin
        dec_c   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (valid_d) begin
            case (opc)
                OP_IMM: begin
                    dec_c.regwrite = 1'b1; dec_c.alusrc = 1'b1;
                    dec_c.aluctrl = {f7b, f3}; use_rs1 = 1'b1;
                end
                OP_LOAD: begin
                    dec_c.regwrite = 1'b1; dec_c.alusrc = 1'b1;
                    dec_c.resultsrc = 1'b1; use_rs1 = 1'b1;
                end
                OP_STORE: begin
                    dec_c.alusrc = 1'b1; dec_c.memwrite = 1'b1;
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_BR: begin
                    dec_c.aluctrl = {1'b0, ~f3[2], f3[2], f3[1]};
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_REG: begin
                    dec_c.regwrite = 1'b1; dec_c.aluctrl = {f7b, f3};
                    use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_LUI: begin
                    dec_c.regwrite = 1'b1; dec_c.alusrc = 1'b1; dec_c.aluctrl = 4'hF;
                end
                OP_AUI: begin
                    dec_c.regwrite = 1'b1; dec_c.alusrc = 1'b1; dec_c.addupper = 1'b1;
                end
                OP_JAL: begin
                    dec_c.regwrite = 1'b1; dec_c.pcwritemux = 1'b1;
                end
                OP_JALR: begin
                    dec_c.regwrite = 1'b1; dec_c.alusrc = 1'b1; dec_c.jbmux = 1'b1;
                    dec_c.pcwritemux = 1'b1; use_rs1 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The extender format follows the opcode alone; valid_d only gates controls
    always_comb begin
        case (opc)
            OP_IMM, OP_LOAD: immsrc_d = 3'd0;
            OP_LUI, OP_AUI:  immsrc_d = 3'd1;
            OP_STORE:        immsrc_d = 3'd2;
            OP_BR:           immsrc_d = 3'd3;
            OP_REG:          immsrc_d = 3'd7;
            default:         immsrc_d = 3'd4;
        endcase
    end

    assign wr_e = de_q.c.regwrite & vld_pipe_q[0];
    assign wr_m = em_q.regwrite   & vld_pipe_q[1];
    assign wr_w = mw_q.regwrite   & vld_pipe_q[2];

    function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] a,
                                     input logic [4:0] b);
        return (rd != 5'd0) && ((a == rd) || (b == rd));
    endfunction

    // W never interlocks: the regfile writes through to the D-stage read
    always_comb begin
        if (FWD_EN)
            hazard = de_q.c.resultsrc & vld_pipe_q[0] & src_hit(de_q.rd, rs1_d, rs2_d);
        else
            hazard = (wr_e & src_hit(de_q.rd, rs1_d, rs2_d)) |
                     (wr_m & src_hit(em_q.rd, rs1_d, rs2_d));
    end

    assign stall_f = hazard & ~branch_taken_e;
    assign stall_d = stall_f;
    assign flush_d = branch_taken_e;
    assign flush_e = hazard | branch_taken_e;

    always_comb begin
        de_d = flush_e ? '0 : '{c: dec_c, rd: rd_d, rs1: rs1_d, rs2: rs2_d};
        em_d = '{regwrite: de_q.c.regwrite, memwrite: de_q.c.memwrite,
                 resultsrc: de_q.c.resultsrc, pcwritemux: de_q.c.pcwritemux, rd: de_q.rd};
        mw_d = '{regwrite: em_q.regwrite, resultsrc: em_q.resultsrc,
                 pcwritemux: em_q.pcwritemux, rd: em_q.rd};
        vld_pipe_d  = {vld_pipe_q[STAGES-1:0], valid_d & ~flush_e};
        stall_cnt_d = (stall_d && !(&stall_cnt_q)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
        flush_cnt_d = (flush_e && !(&flush_cnt_q)) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q        <= '0;
            em_q        <= '0;
            mw_q        <= '0;
            vld_pipe_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            de_q        <= de_d;
            em_q        <= em_d;
            mw_q        <= mw_d;
            vld_pipe_q  <= vld_pipe_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    logic [1:0][4:0] fwd_rs;
    logic [1:0][1:0] fwd_sel;
    assign fwd_rs = {de_q.rs2, de_q.rs1};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        pipe_cu_fwd #(.FWD_EN(FWD_EN)) u_fwd (
            .rs_i   (fwd_rs[g]),
            .rd_m_i (em_q.rd),
            .rd_w_i (mw_q.rd),
            .wr_m_i (wr_m),
            .wr_w_i (wr_w),
            .sel_o  (fwd_sel[g])
        );
    end

    assign fwd_a_e      = fwd_sel[0];
    assign fwd_b_e      = fwd_sel[1];
    assign regwrite_e   = de_q.c.regwrite;
    assign alusrc_e     = de_q.c.alusrc;
    assign memwrite_e   = de_q.c.memwrite;
    assign resultsrc_e  = de_q.c.resultsrc;
    assign pcwritemux_e = de_q.c.pcwritemux;
    assign jbmux_e      = de_q.c.jbmux;
    assign addupper_e   = de_q.c.addupper;
    assign aluctrl_e    = de_q.c.aluctrl;
    assign rd_e         = de_q.rd;
    assign regwrite_m   = em_q.regwrite;
    assign memwrite_m   = em_q.memwrite;
    assign resultsrc_m  = em_q.resultsrc;
    assign pcwritemux_m = em_q.pcwritemux;
    assign rd_m         = em_q.rd;
    assign regwrite_w   = mw_q.regwrite;
    assign resultsrc_w  = mw_q.resultsrc;
    assign pcwritemux_w = mw_q.pcwritemux;
    assign rd_w         = mw_q.rd;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
endmodule
